// File: rtl/note_player_pkg.sv
// Shared definitions for the note player: FSM encoding, default widths and
// the note numbers with special meaning.
package note_player_pkg;

  localparam int PHASE_W_DEF  = 20;
  localparam int SAMPLE_W_DEF = 16;
  // Width of the phase slice used to address one full sine period.
  localparam int IDX_W        = 10;

  localparam logic [5:0] REST_NOTE = 6'd0;
  localparam logic [5:0] A4_NOTE   = 6'd49;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOOKUP  = 2'd1,
    PLAYING = 2'd2
  } state_t;

endpackage

// File: rtl/note_player_freq_rom.sv
// Note index to phase-step table. The step is the per-sample phase increment
// for a 2^20 phase wheel at 48 kHz: round(440 * 2^((n-49)/12) * 2^20 / 48000).
// Note 0 is a rest and yields a step of zero. The output is registered, so a
// new note's step is available one cycle after the note index changes.
module note_freq_rom
  import note_player_pkg::*;
#(
  parameter int STEP_W = PHASE_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [5:0]        note_i,
  output logic [STEP_W-1:0] step_o
);

  logic [19:0]       step_d;
  logic [STEP_W-1:0] step_q;

  // Combinational table lookup, values generated offline.
  always_comb begin
    step_d = 20'd0;
    case (note_i)
      REST_NOTE: step_d = 20'd0;
      6'd1:  step_d = 20'd601;   6'd2:  step_d = 20'd636;   6'd3:  step_d = 20'd674;   6'd4:  step_d = 20'd714;
      6'd5:  step_d = 20'd757;   6'd6:  step_d = 20'd802;   6'd7:  step_d = 20'd850;   6'd8:  step_d = 20'd900;
      6'd9:  step_d = 20'd954;   6'd10: step_d = 20'd1010;  6'd11: step_d = 20'd1070;  6'd12: step_d = 20'd1134;
      6'd13: step_d = 20'd1201;  6'd14: step_d = 20'd1273;  6'd15: step_d = 20'd1349;  6'd16: step_d = 20'd1429;
      6'd17: step_d = 20'd1514;  6'd18: step_d = 20'd1604;  6'd19: step_d = 20'd1699;  6'd20: step_d = 20'd1800;
      6'd21: step_d = 20'd1907;  6'd22: step_d = 20'd2021;  6'd23: step_d = 20'd2141;  6'd24: step_d = 20'd2268;
      6'd25: step_d = 20'd2403;  6'd26: step_d = 20'd2546;  6'd27: step_d = 20'd2697;  6'd28: step_d = 20'd2858;
      6'd29: step_d = 20'd3028;  6'd30: step_d = 20'd3208;  6'd31: step_d = 20'd3398;  6'd32: step_d = 20'd3600;
      6'd33: step_d = 20'd3815;  6'd34: step_d = 20'd4041;  6'd35: step_d = 20'd4282;  6'd36: step_d = 20'd4536;
      6'd37: step_d = 20'd4806;  6'd38: step_d = 20'd5092;  6'd39: step_d = 20'd5395;  6'd40: step_d = 20'd5715;
      6'd41: step_d = 20'd6055;  6'd42: step_d = 20'd6415;  6'd43: step_d = 20'd6797;  6'd44: step_d = 20'd7201;
      6'd45: step_d = 20'd7629;  6'd46: step_d = 20'd8083;  6'd47: step_d = 20'd8563;  6'd48: step_d = 20'd9072;
      6'd49: step_d = 20'd9612;  6'd50: step_d = 20'd10184; 6'd51: step_d = 20'd10789; 6'd52: step_d = 20'd11431;
      6'd53: step_d = 20'd12110; 6'd54: step_d = 20'd12830; 6'd55: step_d = 20'd13593; 6'd56: step_d = 20'd14402;
      6'd57: step_d = 20'd15258; 6'd58: step_d = 20'd16165; 6'd59: step_d = 20'd17127; 6'd60: step_d = 20'd18145;
      6'd61: step_d = 20'd19224; 6'd62: step_d = 20'd20367; 6'd63: step_d = 20'd21578;
      default: step_d = 20'd0;
    endcase
  end

  // Register the looked-up step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) step_q <= '0;
    else       step_q <= STEP_W'(step_d);
  end

  assign step_o = step_q;

endmodule

// File: rtl/note_player.sv
// Plays one note at a time: counts down its beats and turns sample requests
// into signed sine samples using a phase accumulator and an external
// quarter-wave ROM.
//
// Handshakes: new_note is accepted only in a cycle where player_ready is
// high; in any other cycle it is ignored. generate_next_sample is accepted
// when the sample pipeline is empty and answered exactly three cycles later
// by a one-cycle new_sample_ready with sample_out valid; requests arriving
// while a sample is in flight are dropped. done_with_note pulses for one
// cycle in the cycle the last beat is consumed.
module note_player
  import note_player_pkg::*;
#(
  parameter int PHASE_W  = PHASE_W_DEF,
  parameter int SAMPLE_W = SAMPLE_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                play,
  input  logic                new_note,
  input  logic [5:0]          note,
  input  logic [5:0]          duration,
  input  logic                beat,
  input  logic                generate_next_sample,
  input  logic [SAMPLE_W-1:0] sine_data,
  output logic [7:0]          sine_addr,
  output logic [SAMPLE_W-1:0] sample_out,
  output logic                new_sample_ready,
  output logic                player_ready,
  output logic                done_with_note,
  output state_t              dbg_state_o
);

  state_t              state_q;
  logic [5:0]          note_q;
  logic [5:0]          remaining_q;
  logic                ready_q;
  logic [PHASE_W-1:0]  phase_q;
  logic [PHASE_W-1:0]  phase_d;
  logic [PHASE_W-1:0]  step;
  logic [IDX_W-1:0]    idx;
  logic [7:0]          addr_q;
  logic                s1_valid_q, s1_neg_q, s1_zero_q;
  logic                s2_valid_q, s2_neg_q, s2_zero_q;
  logic                nsr_q;
  logic [SAMPLE_W-1:0] sample_q;
  logic                done_w;
  logic                busy;
  logic                take;
  logic                advance;

  note_freq_rom #(.STEP_W(PHASE_W)) u_freq_rom (
    .clk    (clk),
    .reset  (reset),
    .note_i (note_q),
    .step_o (step)
  );

  // A zero-length note finishes at once; otherwise the beat that takes the
  // count from 1 to 0 finishes it.
  assign done_w = (state_q == PLAYING) &&
                  ((remaining_q == 6'd0) || ((remaining_q == 6'd1) && beat && play));

  // Note sequencing: latch in IDLE, one cycle for the step lookup, then play.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      note_q      <= REST_NOTE;
      remaining_q <= 6'd0;
      ready_q     <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (new_note) begin
            note_q      <= note;
            remaining_q <= duration;
            state_q     <= LOOKUP;
            ready_q     <= 1'b0;
          end
        end
        LOOKUP: state_q <= PLAYING;
        PLAYING: begin
          if (done_w) begin
            remaining_q <= 6'd0;
            state_q     <= IDLE;
            ready_q     <= 1'b1;
          end else if (beat && play) begin
            remaining_q <= remaining_q - 6'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // The output cycle counts as busy so requests need four-cycle spacing.
  assign busy    = s1_valid_q | s2_valid_q | nsr_q;
  assign take    = generate_next_sample & ~busy;
  assign advance = (state_q == PLAYING) & play;
  assign phase_d = advance ? (phase_q + step) : phase_q;
  assign idx     = phase_d[PHASE_W-1 -: IDX_W];

  // Three-stage sample pipeline: phase/address, ROM read, sign and output.
  // Whether a sample is silent is decided at issue, so later note changes
  // never alter a sample already in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q    <= '0;
      addr_q     <= 8'd0;
      s1_valid_q <= 1'b0;
      s1_neg_q   <= 1'b0;
      s1_zero_q  <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_neg_q   <= 1'b0;
      s2_zero_q  <= 1'b0;
      nsr_q      <= 1'b0;
      sample_q   <= '0;
    end else begin
      if ((state_q == IDLE) && new_note) phase_q <= '0;
      else if (take && advance)          phase_q <= phase_d;
      s1_valid_q <= take;
      if (take) begin
        // Odd quadrants read the quarter wave backwards.
        addr_q    <= idx[8] ? ~idx[7:0] : idx[7:0];
        s1_neg_q  <= idx[9];
        s1_zero_q <= ~advance | (note_q == REST_NOTE);
      end
      s2_valid_q <= s1_valid_q;
      s2_neg_q   <= s1_neg_q;
      s2_zero_q  <= s1_zero_q;
      nsr_q      <= s2_valid_q;
      if (s2_valid_q) begin
        if (s2_zero_q)     sample_q <= '0;
        else if (s2_neg_q) sample_q <= -sine_data;
        else               sample_q <= sine_data;
      end
    end
  end

  assign sine_addr        = addr_q;
  assign sample_out       = sample_q;
  assign new_sample_ready = nsr_q;
  assign player_ready     = ready_q;
  assign done_with_note   = done_w;
  assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_note_player.sv
// Bench for note_player: directed note sequences plus random play, with a
// sample scoreboard fed at request time and drained by a monitor process.
module tb_note_player;
  import note_player_pkg::*;

  localparam real PI = 3.14159265358979323846;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        play = 1'b0;
  logic        new_note = 1'b0;
  logic [5:0]  note = 6'd0;
  logic [5:0]  duration = 6'd0;
  logic        beat = 1'b0;
  logic        generate_next_sample = 1'b0;
  logic [15:0] sine_data = 16'd0;
  logic [7:0]  sine_addr;
  logic [15:0] sample_out;
  logic        new_sample_ready;
  logic        player_ready;
  logic        done_with_note;
  state_t      dbg_state_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int since = 10;

  // Scoreboard: expected samples and the cycle each should appear in.
  logic [15:0] exp_q[$];
  int          exp_t_q[$];

  // Behavioural model of the player.
  typedef enum int {M_IDLE, M_LOOK, M_PLAY} mode_t;
  mode_t      m_mode = M_IDLE;
  int         m_note = 0;
  int         m_rem = 0;
  int         m_phase = 0;
  int         m_step = 0;
  bit         addr_pend = 1'b0;
  logic [7:0] addr_exp = 8'd0;

  note_player dut (
    .clk                  (clk),
    .reset                (reset),
    .play                 (play),
    .new_note             (new_note),
    .note                 (note),
    .duration             (duration),
    .beat                 (beat),
    .generate_next_sample (generate_next_sample),
    .sine_data            (sine_data),
    .sine_addr            (sine_addr),
    .sample_out           (sample_out),
    .new_sample_ready     (new_sample_ready),
    .player_ready         (player_ready),
    .done_with_note       (done_with_note),
    .dbg_state_o          (dbg_state_o)
  );

  // Clock and cycle counter.
  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int rnd(input real v);
    if (v >= 0.0) return $rtoi(v + 0.5);
    return -$rtoi(-v + 0.5);
  endfunction

  // Quarter-wave ROM contents: first quarter of a full-scale sine.
  function automatic logic [15:0] rom_fn(input logic [7:0] a);
    return 16'(rnd(32767.0 * $sin(PI * (real'(a) + 0.5) / 512.0)));
  endfunction

  // External ROM with one cycle of read latency.
  always @(posedge clk) sine_data <= rom_fn(sine_addr);

  // Equal-tempered step for a 2^20 phase wheel at 48 kHz.
  function automatic int ref_step(input int n);
    real f;
    if (n == 0) return 0;
    f = 440.0 * (2.0 ** (real'(n - 49) / 12.0));
    return $rtoi(f * 1048576.0 / 48000.0 + 0.5);
  endfunction

  // Full-period sine at the 1/1024 position selected by the phase.
  function automatic logic [15:0] ref_sample(input int ph);
    int k;
    k = ph / 1024;
    return 16'(rnd(32767.0 * $sin(PI * (real'(k) + 0.5) / 512.0)));
  endfunction

  // Which quarter-wave entry the given phase needs.
  function automatic logic [7:0] ref_addr(input int ph);
    int k, pos, quadrant;
    k = ph / 1024;
    quadrant = k / 256;
    pos = k % 256;
    return 8'((quadrant % 2 == 1) ? (255 - pos) : pos);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pop and compare whenever the DUT presents a sample.
  always @(negedge clk) begin
    if (exp_t_q.size() > 0 && cyc > exp_t_q[0]) begin
      checks++;
      errors++;
      $display("FAIL missing_sample: got none expected pulse at cycle %0d (cycle %0d)", exp_t_q[0], cyc);
      void'(exp_q.pop_front());
      void'(exp_t_q.pop_front());
    end
    if (new_sample_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_sample: got pulse value %0h expected no pulse (cycle %0d)", sample_out, cyc);
      end else begin
        check("sample_value", sample_out, exp_q.pop_front());
        check("sample_latency", cyc, exp_t_q.pop_front());
      end
    end
  end

  // One clock cycle of stimulus; checks the cycle's outputs, then advances
  // the model past the edge.
  task automatic cycle(input bit b, input bit s, input bit nn, input logic [5:0] n, input logic [5:0] d);
    bit exp_done, adv;
    beat = b;
    generate_next_sample = s;
    new_note = nn;
    note = n;
    duration = d;
    @(negedge clk);
    if (addr_pend) begin
      check("sine_addr", sine_addr, addr_exp);
      addr_pend = 1'b0;
    end
    exp_done = (m_mode == M_PLAY) && (m_rem == 0 || (m_rem == 1 && b && play));
    check("done_with_note", done_with_note, exp_done);
    check("player_ready", player_ready, m_mode == M_IDLE);
    if (s) begin
      adv = (m_mode == M_PLAY) && play;
      if (adv) m_phase = (m_phase + m_step) % 1048576;
      addr_exp = ref_addr(m_phase);
      addr_pend = 1'b1;
      exp_q.push_back((adv && m_note != 0) ? ref_sample(m_phase) : 16'd0);
      exp_t_q.push_back(cyc + 3);
      since = 0;
    end
    @(posedge clk);
    #1;
    since++;
    case (m_mode)
      M_IDLE: if (nn) begin
        m_mode = M_LOOK;
        m_note = int'(n);
        m_rem = int'(d);
        m_phase = 0;
      end
      M_LOOK: begin
        m_mode = M_PLAY;
        m_step = ref_step(m_note);
      end
      default: begin
        if (exp_done) m_mode = M_IDLE;
        else if (b && play) m_rem--;
      end
    endcase
    beat = 1'b0;
    generate_next_sample = 1'b0;
    new_note = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 6'd0, 6'd0);
  endtask

  // Strobe then wait out the pipeline.
  task automatic strobe(input bit b);
    cycle(b, 1'b1, 1'b0, 6'd0, 6'd0);
    idle(3);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit          rb, rs;
    logic [5:0]  rn, rd;
    int          budget;

    // Reset behaviour.
    repeat (2) @(negedge clk);
    check("rst_ready", player_ready, 1'b1);
    check("rst_sample", sample_out, 16'd0);
    check("rst_nsr", new_sample_ready, 1'b0);
    check("rst_done", done_with_note, 1'b0);
    check("rst_state", dbg_state_o, IDLE);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // A request while idle yields a silent sample.
    strobe(1'b0);

    // A4 for two beats; the second beat coincides with a sample request.
    play = 1'b1;
    cycle(1'b0, 1'b1, 1'b1, A4_NOTE, 6'd2);
    cycle(1'b0, 1'b0, 1'b0, 6'd0, 6'd0);
    cycle(1'b1, 1'b0, 1'b0, 6'd0, 6'd0);
    idle(1);
    strobe(1'b1);

    // A4 held for 27 requests.
    cycle(1'b0, 1'b0, 1'b1, A4_NOTE, 6'd5);
    idle(3);
    for (int j = 0; j < 27; j++) begin
      cycle(1'b0, 1'b1, 1'b0, 6'd0, 6'd0);
      if (j == 26) check("addr_after_27", sine_addr, 8'd253);
      idle(3);
    end
    // A new note while playing must be ignored.
    cycle(1'b0, 1'b0, 1'b1, REST_NOTE, 6'd1);

    // Paused: beats and requests do not move the note.
    play = 1'b0;
    for (int j = 0; j < 3; j++) strobe(1'b1);
    play = 1'b1;
    strobe(1'b0);
    for (int j = 0; j < 5; j++) begin
      cycle(1'b1, 1'b0, 1'b0, 6'd0, 6'd0);
      idle(1);
    end

    // Rest note for one beat.
    cycle(1'b0, 1'b0, 1'b1, REST_NOTE, 6'd1);
    cycle(1'b0, 1'b1, 1'b0, 6'd0, 6'd0);
    idle(3);
    for (int j = 0; j < 2; j++) strobe(1'b0);
    cycle(1'b1, 1'b0, 1'b0, 6'd0, 6'd0);
    idle(1);

    // Zero-length note, with new notes offered while it is busy.
    cycle(1'b0, 1'b0, 1'b1, 6'd10, 6'd0);
    cycle(1'b0, 1'b0, 1'b1, 6'd20, 6'd3);
    cycle(1'b0, 1'b0, 1'b1, 6'd30, 6'd3);
    idle(2);

    // Random notes, beats, pauses and requests.
    for (int k = 0; k < 6; k++) begin
      rn = 6'($urandom_range(0, 63));
      rd = 6'($urandom_range(1, 3));
      cycle(1'b0, since >= 4, 1'b1, rn, rd);
      budget = 0;
      while (m_mode != M_IDLE && budget < 300) begin
        play = ($urandom_range(0, 3) != 0);
        rb = ($urandom_range(0, 2) == 0);
        rs = (since >= 4) && ($urandom_range(0, 1) == 1);
        cycle(rb, rs, 1'b0, 6'd0, 6'd0);
        budget++;
      end
      if (m_mode != M_IDLE) begin
        checks++;
        errors++;
        $display("FAIL note_timeout: got note still playing expected done within 300 cycles");
      end
      idle(1);
    end

    // Reset during a note with a sample in flight.
    play = 1'b1;
    idle(4);
    cycle(1'b0, 1'b0, 1'b1, A4_NOTE, 6'd5);
    idle(3);
    cycle(1'b0, 1'b1, 1'b0, 6'd0, 6'd0);
    reset = 1'b1;
    #1;
    check("midrst_ready", player_ready, 1'b1);
    check("midrst_state", dbg_state_o, IDLE);
    check("midrst_done", done_with_note, 1'b0);
    check("midrst_nsr", new_sample_ready, 1'b0);
    exp_q.delete();
    exp_t_q.delete();
    addr_pend = 1'b0;
    m_mode = M_IDLE;
    m_phase = 0;
    m_note = 0;
    m_rem = 0;
    repeat (3) begin
      @(negedge clk);
      check("midrst_hold_nsr", new_sample_ready, 1'b0);
      check("midrst_hold_done", done_with_note, 1'b0);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    since = 10;
    idle(2);
    strobe(1'b0);

    // Drain the scoreboard.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) idle(1);
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
